// File: rtl/dac_pkg.sv
// Shared types and helpers for the multi-channel DAC output driver.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } dac_state_t;

    function automatic int mid_scale(input int unsigned width);
        return 1 << (width - 1);
    endfunction

    // Clamp a signed value into the unsigned code range [0, 2^width - 1].
    function automatic logic [31:0] saturate(input logic signed [63:0] value,
                                             input int unsigned width);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< width) - 64'sd1;
        if (value < 64'sd0) return '0;
        if (value > hi) return hi[31:0];
        return value[31:0];
    endfunction

endpackage

// File: rtl/dac_channel_driver_if.sv
// Sample-source and DAC-side signal bundle for dac_channel_driver.
interface dac_channel_driver_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 14,
    parameter int GAIN_W = 16
);
    logic                         enable;
    logic [NUM_CH-1:0]            src_sel;
    logic [NUM_CH*DATA_W-1:0]     lut_data;
    logic                         lut_valid;
    logic [NUM_CH*DATA_W-1:0]     ext_data;
    logic                         ext_valid;
    logic [NUM_CH*GAIN_W-1:0]     gain;
    logic [NUM_CH*(DATA_W+1)-1:0] offset;
    logic [NUM_CH*DATA_W-1:0]     dac_data;
    logic [NUM_CH-1:0]            dac_clk;
    logic [NUM_CH-1:0]            dac_wrt;
    logic                         DAC_MODE;
    logic                         POWER_ON;
    logic [1:0]                   state_o;
    logic                         data_valid_dac_export;

    modport master (
        output enable, src_sel, lut_data, lut_valid, ext_data, ext_valid, gain, offset,
        input  dac_data, dac_clk, dac_wrt, DAC_MODE, POWER_ON, state_o, data_valid_dac_export
    );

    modport slave (
        input  enable, src_sel, lut_data, lut_valid, ext_data, ext_valid, gain, offset,
        output dac_data, dac_clk, dac_wrt, DAC_MODE, POWER_ON, state_o, data_valid_dac_export
    );

endinterface

// File: rtl/dac_scale_sat.sv
// One channel's two-stage gain/offset/saturate pipeline (offset-binary in and out).
module dac_scale_sat
    import dac_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x,
    input  logic [GAIN_W-1:0] gain,
    input  logic [DATA_W:0]   offset,
    output logic              out_valid,
    output logic [DATA_W-1:0] y
);
    localparam int PW = DATA_W + GAIN_W + 2;
    localparam logic signed [PW:0] MID = (PW+1)'(mid_scale(DATA_W));

    logic signed [DATA_W:0] d;
    logic signed [PW-1:0]   prod_q;
    logic signed [DATA_W:0] off_q;
    logic                   v1_q;
    logic signed [PW:0]     sum;
    logic [31:0]            sat;

    assign d = $signed({1'b0, x}) - $signed({2'b01, {(DATA_W-1){1'b0}}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            prod_q <= '0;
            off_q  <= '0;
        end else begin
            v1_q   <= in_valid;
            prod_q <= PW'(d) * $signed(PW'({1'b0, gain}));
            off_q  <= offset;
        end
    end

    // Arithmetic shift floors toward -inf, matching the intended truncation.
    always_comb begin
        sum = (PW+1)'(prod_q >>> GAIN_FRAC) + MID + (PW+1)'(off_q);
        sat = saturate(64'(sum), DATA_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= v1_q;
            y         <= sat[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/dac_channel_driver.sv
// Multi-channel DAC driver: per-channel scaling, soft ramp to/from idle, settled-update strobe.
module dac_channel_driver
    import dac_pkg::*;
#(
    parameter int DATA_W       = 14,
    parameter int NUM_CH       = 2,
    parameter int GAIN_W       = 16,
    parameter int GAIN_FRAC    = 10,
    parameter int IDLE_LEVEL   = 8192,
    parameter int RAMP_STEP    = 64,
    parameter int SETTLE_DELAY = 10
) (
    input logic CLK_65,
    input logic reset_n,
    dac_channel_driver_if.slave bus
);
    localparam int CNT_W = $clog2(SETTLE_DELAY + 1);
    localparam logic [DATA_W-1:0] IDLE_CODE  = DATA_W'(IDLE_LEVEL);
    localparam logic [CNT_W-1:0]  SETTLE_MAX = CNT_W'(SETTLE_DELAY);

    dac_state_t        state, state_next;
    logic [NUM_CH-1:0] sv;
    logic [DATA_W-1:0] y        [NUM_CH];
    logic [DATA_W-1:0] target   [NUM_CH];
    logic [DATA_W-1:0] dac_q    [NUM_CH];
    logic [DATA_W-1:0] dac_next [NUM_CH];
    logic              seen;
    logic [CNT_W-1:0]  settle_cnt, settle_next;
    logic              export_q, export_next;
    logic              all_at_target, all_at_idle, update0;

    function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] dst);
        int diff;
        diff = int'(dst) - int'(cur);
        if (diff > RAMP_STEP) return cur + DATA_W'(RAMP_STEP);
        if (diff < -RAMP_STEP) return cur - DATA_W'(RAMP_STEP);
        return dst;
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic              v_in;
        logic [DATA_W-1:0] x;

        assign v_in = bus.src_sel[ch] ? bus.lut_valid : bus.ext_valid;
        assign x    = bus.src_sel[ch] ? bus.lut_data[ch*DATA_W +: DATA_W]
                                      : bus.ext_data[ch*DATA_W +: DATA_W];

        dac_scale_sat #(
            .DATA_W   (DATA_W),
            .GAIN_W   (GAIN_W),
            .GAIN_FRAC(GAIN_FRAC)
        ) u_scale (
            .clk      (CLK_65),
            .rst_n    (reset_n),
            .in_valid (v_in),
            .x        (x),
            .gain     (bus.gain[ch*GAIN_W +: GAIN_W]),
            .offset   (bus.offset[ch*(DATA_W+1) +: DATA_W+1]),
            .out_valid(sv[ch]),
            .y        (y[ch])
        );

        assign bus.dac_data[ch*DATA_W +: DATA_W] = dac_q[ch];
    end

    always_comb begin
        all_at_target = 1'b1;
        all_at_idle   = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (dac_q[c] != target[c]) all_at_target = 1'b0;
            if (dac_q[c] != IDLE_CODE) all_at_idle = 1'b0;
        end

        state_next = state;
        case (state)
            IDLE:      if (bus.enable && seen) state_next = RAMP_UP;
            RAMP_UP:   if (!bus.enable) state_next = RAMP_DOWN;
                       else if (all_at_target) state_next = RUN;
            RUN:       if (!bus.enable) state_next = RAMP_DOWN;
            RAMP_DOWN: if (bus.enable) state_next = RAMP_UP;
                       else if (all_at_idle) state_next = IDLE;
        endcase

        // An enable drop in RUN blocks the same-cycle sample from the output.
        update0 = (state == RUN) && bus.enable && sv[0];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dac_next[c] = dac_q[c];
            case (state)
                IDLE:      dac_next[c] = IDLE_CODE;
                RAMP_UP:   dac_next[c] = step_toward(dac_q[c], target[c]);
                RUN:       if (bus.enable && sv[c]) dac_next[c] = y[c];
                RAMP_DOWN: dac_next[c] = step_toward(dac_q[c], IDLE_CODE);
            endcase
        end

        settle_next = '0;
        if (state == RUN && bus.enable) begin
            settle_next = settle_cnt;
            if (update0 && settle_cnt != SETTLE_MAX) settle_next = settle_cnt + 1'b1;
        end
        export_next = update0 && (settle_next == SETTLE_MAX);
    end

    always_ff @(posedge CLK_65) begin
        if (!reset_n) begin
            state      <= IDLE;
            seen       <= 1'b0;
            settle_cnt <= '0;
            export_q   <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                dac_q[c]  <= IDLE_CODE;
                target[c] <= IDLE_CODE;
            end
        end else begin
            state      <= state_next;
            seen       <= seen | (|sv);
            settle_cnt <= settle_next;
            export_q   <= export_next;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                dac_q[c] <= dac_next[c];
                if (sv[c]) target[c] <= y[c];
            end
        end
    end

    assign bus.dac_clk               = {NUM_CH{CLK_65}};
    assign bus.dac_wrt               = {NUM_CH{CLK_65}};
    assign bus.DAC_MODE              = 1'b1;
    assign bus.POWER_ON              = 1'b1;
    assign bus.state_o               = state;
    assign bus.data_valid_dac_export = export_q;

endmodule

// File: tb/tb_dac_channel_driver.sv
// Directed + randomized bench for dac_channel_driver against a cycle-level reference model.
module tb_dac_channel_driver;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dac_channel_driver_if bus ();

    dac_channel_driver dut (
        .CLK_65 (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        bit [1:0] v;
        int       y [2];
    } entry_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    entry_t pipe[$];
    int     m_mode;
    int     m_dac [2];
    int     m_tgt [2];
    int     m_cnt;
    bit     m_seen;
    bit     m_exp;

    function automatic int scale(int x, int g, int off);
        longint p;
        longint r;
        p = ((longint'(x) - 64'sd8192) * longint'(g)) >>> 10;
        r = p + 64'sd8192 + longint'(off);
        if (r < 0) return 0;
        if (r > 16383) return 16383;
        return int'(r);
    endfunction

    function automatic int approach(int cur, int dst);
        if (dst - cur > 64) return cur + 64;
        if (dst - cur < -64) return cur - 64;
        return dst;
    endfunction

    function automatic entry_t empty_entry();
        entry_t z;
        z.v = '0;
        z.y = '{0, 0};
        return z;
    endfunction

    function automatic entry_t sample_inputs();
        entry_t e;
        for (int c = 0; c < 2; c++) begin
            logic        sel;
            logic [13:0] x;
            logic [15:0] g;
            logic signed [14:0] o;
            sel    = bus.src_sel[c];
            e.v[c] = sel ? bus.lut_valid : bus.ext_valid;
            x      = sel ? bus.lut_data[c*14 +: 14] : bus.ext_data[c*14 +: 14];
            g      = bus.gain[c*16 +: 16];
            o      = bus.offset[c*15 +: 15];
            e.y[c] = scale(int'(x), int'(g), int'(o));
        end
        return e;
    endfunction

    function automatic int dac(int c);
        return int'(bus.dac_data[c*14 +: 14]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_dac  = '{8192, 8192};
        m_tgt  = '{8192, 8192};
        m_seen = 0;
        m_cnt  = 0;
        m_exp  = 0;
        pipe.delete();
        pipe.push_back(empty_entry());
        pipe.push_back(empty_entry());
    endtask

    task automatic model_edge(input bit en, input entry_t e);
        bit at_t, at_i, upd0;
        int nd [2];
        int nmode;
        at_t = 1;
        at_i = 1;
        for (int c = 0; c < 2; c++) begin
            if (m_dac[c] != m_tgt[c]) at_t = 0;
            if (m_dac[c] != 8192) at_i = 0;
        end
        upd0 = (m_mode == 2) && en && e.v[0];
        for (int c = 0; c < 2; c++) begin
            case (m_mode)
                0:       nd[c] = 8192;
                1:       nd[c] = approach(m_dac[c], m_tgt[c]);
                2:       nd[c] = (en && e.v[c]) ? e.y[c] : m_dac[c];
                default: nd[c] = approach(m_dac[c], 8192);
            endcase
        end
        if (m_mode == 2 && en) begin
            if (upd0 && m_cnt < 10) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        m_exp = upd0 && (m_cnt == 10);
        nmode = m_mode;
        case (m_mode)
            0: if (en && m_seen) nmode = 1;
            1: if (!en) nmode = 3; else if (at_t) nmode = 2;
            2: if (!en) nmode = 3;
            default: if (en) nmode = 1; else if (at_i) nmode = 0;
        endcase
        for (int c = 0; c < 2; c++) begin
            m_dac[c] = nd[c];
            if (e.v[c]) m_tgt[c] = e.y[c];
        end
        if (e.v != 2'b00) m_seen = 1;
        m_mode = nmode;
    endtask

    task automatic tick();
        entry_t cur, e;
        bit rst_now, en_now;
        cur     = sample_inputs();
        rst_now = reset_n;
        en_now  = bus.enable;
        @(posedge clk);
        if (!rst_now) begin
            model_reset();
        end else begin
            e = pipe.pop_front();
            pipe.push_back(cur);
            model_edge(en_now, e);
        end
        #1;
        check("dac0", 32'(dac(0)), m_dac[0]);
        check("dac1", 32'(dac(1)), m_dac[1]);
        check("state", 32'(bus.state_o), m_mode);
        check("export", 32'(bus.data_valid_dac_export), 32'(m_exp));
    endtask

    task automatic wait_state(input int want, input int limit, input string tag);
        int k = 0;
        while (int'(bus.state_o) != want && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.state_o), want);
    endtask

    initial begin
        int steps, maxstep, prev, k, o0, o1;
        bus.enable    = 0;
        bus.src_sel   = '0;
        bus.lut_data  = '0;
        bus.lut_valid = 0;
        bus.ext_data  = '0;
        bus.ext_valid = 0;
        bus.gain      = {16'd1024, 16'd1024};
        bus.offset    = '0;
        reset_n       = 0;
        model_reset();

        repeat (3) tick();
        check("rst_dac0", 32'(dac(0)), 8192);
        check("rst_dac1", 32'(dac(1)), 8192);
        check("rst_state", 32'(bus.state_o), 0);
        check("rst_export", 32'(bus.data_valid_dac_export), 0);
        reset_n = 1;

        // Disabled with external strobes running: outputs must stay at idle level.
        for (int i = 0; i < 20; i++) begin
            bus.ext_valid = 1'($urandom);
            bus.ext_data  = 28'($urandom);
            tick();
        end
        check("idle_hold0", 32'(dac(0)), 8192);
        check("idle_hold1", 32'(dac(1)), 8192);

        // Full-scale LUT ramp-up.
        bus.ext_valid = 0;
        bus.src_sel   = 2'b11;
        bus.lut_data  = {14'd16383, 14'd16383};
        bus.lut_valid = 1;
        repeat (4) tick();
        bus.enable = 1;
        steps = 0; maxstep = 0; prev = dac(0); k = 0;
        while (int'(bus.state_o) != 2 && k < 300) begin
            tick();
            if (dac(0) != prev) steps++;
            if (dac(0) - prev > maxstep) maxstep = dac(0) - prev;
            prev = dac(0);
            k++;
        end
        check("ramp_reach_run", 32'(bus.state_o), 2);
        check("ramp_steps", steps, 128);
        check("ramp_maxstep", maxstep, 64);
        check("ramp_final", 32'(dac(1)), 16383);

        k = 0;
        while (k < 50) begin
            tick();
            k++;
            if (bus.data_valid_dac_export) break;
        end
        check("settle_updates", k, 10);

        // Randomized traffic including occasional enable drops.
        for (int i = 0; i < 300; i++) begin
            bus.enable    = ($urandom_range(0, 29) != 0);
            bus.src_sel   = 2'($urandom);
            bus.lut_data  = 28'($urandom);
            bus.ext_data  = 28'($urandom);
            bus.lut_valid = 1'($urandom);
            bus.ext_valid = 1'($urandom);
            bus.gain      = {16'($urandom_range(0, 3000)), 16'($urandom_range(0, 3000))};
            o0 = int'($urandom_range(0, 4000)) - 2000;
            o1 = int'($urandom_range(0, 4000)) - 2000;
            bus.offset    = {15'(o1), 15'(o0)};
            tick();
        end
        bus.enable    = 1;
        bus.lut_valid = 1;
        wait_state(2, 400, "rand_to_run");

        // Latency and high saturation.
        bus.src_sel   = 2'b00;
        bus.lut_valid = 0;
        bus.gain      = {16'd1024, 16'd1024};
        bus.offset    = '0;
        bus.ext_data  = {14'd8192, 14'd8192};
        bus.ext_valid = 1;
        tick();
        bus.ext_valid = 0;
        repeat (3) tick();
        check("pre_lat", 32'(dac(0)), 8192);
        bus.ext_data  = {14'd12288, 14'd12288};
        bus.gain      = {16'd2048, 16'd2048};
        bus.ext_valid = 1;
        tick();
        bus.ext_valid = 0;
        check("lat_1", 32'(dac(0)), 8192);
        tick();
        check("lat_2", 32'(dac(0)), 8192);
        tick();
        check("lat_3_sat_high", 32'(dac(0)), 16383);
        repeat (3) tick();
        check("hold0", 32'(dac(0)), 16383);
        check("hold1", 32'(dac(1)), 16383);

        // Low saturation from the most negative offset.
        bus.ext_data  = {14'd8192, 14'd8192};
        bus.gain      = {16'd1024, 16'd1024};
        bus.offset    = {15'h4000, 15'h4000};
        bus.ext_valid = 1;
        tick();
        bus.ext_valid = 0;
        repeat (2) tick();
        check("sat_low", 32'(dac(0)), 0);

        // Back to full scale, then drop enable with a different sample in flight.
        bus.offset    = '0;
        bus.src_sel   = 2'b11;
        bus.lut_data  = {14'd16383, 14'd16383};
        bus.lut_valid = 1;
        repeat (4) tick();
        check("full_scale", 32'(dac(0)), 16383);
        bus.lut_data = {14'd5000, 14'd5000};
        repeat (2) tick();
        bus.enable = 0;
        tick();
        check("drop_hold", 32'(dac(0)), 16383);
        check("drop_state", 32'(bus.state_o), 3);
        bus.lut_valid = 0;
        repeat (59) tick();
        prev          = dac(0);
        bus.enable    = 1;
        bus.lut_data  = {14'd16383, 14'd16383};
        bus.lut_valid = 1;
        tick();
        check("reenable_step", 32'(dac(0)), 32'(prev - 64));
        wait_state(2, 400, "rerun");
        repeat (3) tick();
        check("rerun_level", 32'(dac(0)), 16383);

        // Full ramp-down to idle.
        bus.enable    = 0;
        bus.lut_valid = 0;
        steps = 0; prev = dac(0); k = 0;
        while (int'(bus.state_o) != 0 && k < 400) begin
            tick();
            if (dac(0) != prev) steps++;
            prev = dac(0);
            k++;
        end
        check("down_idle", 32'(bus.state_o), 0);
        check("down_steps", steps, 128);
        check("down_level", 32'(dac(0)), 8192);

        // Reset in the middle of a ramp-up.
        bus.enable = 1;
        repeat (20) tick();
        check("mid_ramp_state", 32'(bus.state_o), 1);
        reset_n = 0;
        tick();
        check("rst_mid_dac0", 32'(dac(0)), 8192);
        check("rst_mid_dac1", 32'(dac(1)), 8192);
        check("rst_mid_state", 32'(bus.state_o), 0);
        check("rst_mid_export", 32'(bus.data_valid_dac_export), 0);
        reset_n = 1;
        repeat (5) tick();
        check("post_rst_idle", 32'(bus.state_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
